// File: rtl/sc_config_pkg.sv
// Shared constants and types for the scan converter config shadow path.
// Word indices name the six 32-bit config words carried on the bus.
package sc_config_pkg;

  localparam int NUM_CFG_REGS = 6;
  localparam int CFG_W        = 32;

  localparam int H_CFG    = 0;
  localparam int H_CFG2   = 1;
  localparam int V_CFG    = 2;
  localparam int MISC_CFG = 3;
  localparam int SL_CFG   = 4;
  localparam int SL_CFG2  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    APPLY = 2'd2
  } shadow_state_t;

endpackage

// File: rtl/sc_sync_edge.sv
// Two-flop synchronizer, delay flop and polarity-selected edge pulse
// for asynchronous video strobes. Ports: clk_i, rst_i, async_i, edge_o.
module sc_sync_edge #(
  parameter bit POL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic dly_q, dly_d;

  always_comb begin
    s1_d  = async_i;
    s2_d  = s1_q;
    dly_d = s2_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      dly_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      dly_q <= dly_d;
    end
  end

  assign edge_o = POL ? (s2_q & ~dly_q)
                      : (~s2_q & dly_q);

endmodule

// File: rtl/sc_config_shadow_ctrl.sv
// Frame-synchronous config commit: snapshot on commit, apply atomically
// at the next active VSYNC edge (or at once with immediate_i).
// Ports: clk_i/rst_i, cfg_staged_i, commit_i, immediate_i, clr_flags_i,
// vsync_i in; cfg_active_o, update_stb_o, pending_o, commit_cnt_o,
// timeout_o out. SC_SHADOW_TIMEOUT_EN enables the ARMED wait limit.
module sc_config_shadow_ctrl
  import sc_config_pkg::*;
#(
  parameter int NUM_REGS       = NUM_CFG_REGS,
  parameter bit VSYNC_POL      = 1'b1,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REGS*32-1:0]   cfg_staged_i,
  input  logic                     commit_i,
  input  logic                     immediate_i,
  input  logic                     clr_flags_i,
  input  logic                     vsync_i,
  output logic [NUM_REGS*32-1:0]   cfg_active_o,
  output logic                     update_stb_o,
  output logic                     pending_o,
  output logic [7:0]               commit_cnt_o,
  output logic                     timeout_o
);

  localparam int CW = NUM_REGS * CFG_W;

  shadow_state_t state_q, state_d;

  logic [CW-1:0] shadow_q, shadow_d;
  logic [CW-1:0] active_q, active_d;
  logic          stb_q, stb_d;
  logic [7:0]    cnt_q, cnt_d;

  logic vs_edge;
  logic snap;
  logic expire;
  logic forced;
  logic enter_apply;

  sc_sync_edge #(
    .POL (VSYNC_POL)
  ) u_vs_edge (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (vsync_i),
    .edge_o  (vs_edge)
  );

`ifdef SC_SHADOW_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] timer_q, timer_d;
  logic          tmo_q, tmo_d;

  // Counts down while ARMED; the apply fires on the edge
  // where the count would reach zero.
  always_comb begin
    timer_d = timer_q;
    if (snap)
      timer_d = TMO_LOAD;
    else if (state_q == ARMED && timer_q != '0)
      timer_d = timer_q - 1'b1;
  end

  // A forced apply outranks a same-cycle clear.
  always_comb begin
    tmo_d = tmo_q;
    if (forced)
      tmo_d = 1'b1;
    else if (clr_flags_i)
      tmo_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      tmo_q   <= tmo_d;
    end
  end

  assign expire    = (state_q == ARMED) &&
                     (timer_q <= TW'(1));
  assign timeout_o = tmo_q;
`else
  localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
  logic unused_clr;

  assign unused_clr = clr_flags_i;
  assign expire     = 1'b0;
  assign timeout_o  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      active_q <= '0;
      stb_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      stb_q    <= stb_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    snap    = 1'b0;
    forced  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A VSYNC edge here is ignored, even with a commit.
        if (commit_i) begin
          snap    = 1'b1;
          state_d = immediate_i ? APPLY : ARMED;
        end
      end
      ARMED: begin
        snap = commit_i;
        if (vs_edge || expire) begin
          state_d = APPLY;
          forced  = ~vs_edge;
        end
      end
      APPLY: begin
        if (commit_i) begin
          snap    = 1'b1;
          state_d = immediate_i ? APPLY : ARMED;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates; applying takes shadow_d so a
  // same-cycle re-snapshot is the one that lands.
  always_comb begin
    enter_apply = (state_d == APPLY);
    shadow_d    = snap ? cfg_staged_i : shadow_q;
    active_d    = enter_apply ? shadow_d : active_q;
    stb_d       = enter_apply;
    cnt_d       = enter_apply ? cnt_q + 8'd1 : cnt_q;
  end

  assign cfg_active_o = active_q;
  assign update_stb_o = stb_q;
  assign pending_o    = (state_q == ARMED);
  assign commit_cnt_o = cnt_q;

endmodule
